// File: rtl/shift_reg_pkg.sv
// Shared types and helpers for the multi-mode shift register and its counter.
package shift_reg_pkg;

   typedef enum logic {
      SHIFT_RIGHT = 1'b0,
      SHIFT_LEFT  = 1'b1
   } shift_dir_t;

   // Resolved operation for one clock edge after priority has been applied.
   typedef enum logic [1:0] {
      OP_HOLD,
      OP_SHIFT,
      OP_LOAD,
      OP_CLEAR
   } sr_op_t;

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating shift counter; Done is registered and tracks Count == MAX.
module shift_counter
   import shift_reg_pkg::*;
#(
   parameter int MAX  = 8,
   parameter bit STOP = 1'b1,
   parameter int CW   = cnt_w(MAX)
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Inc,
   input  logic          Zero,
   output logic [CW-1:0] Count,
   output logic          Done
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX);

   logic [CW-1:0] count_q, count_d;
   logic          done_q, done_d;

   always_comb begin
      count_d = count_q;
      if (Zero) begin
         count_d = '0;
      end else if (Inc && !(STOP && done_q) && (count_q != MAX_C)) begin
         count_d = count_q + 1'b1;
      end
      // Computed from the next count so Done rises with the final shift.
      done_d = (count_d == MAX_C);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign Count = count_q;
   assign Done  = done_q;

endmodule

// File: rtl/shift_reg_n.sv
// N-bit multi-mode register: hold, load, clear, logical shift and rotate,
// with a built-in saturating shift counter for word serialisation.
module shift_reg_n
   import shift_reg_pkg::*;
#(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0,
   parameter int               SHIFT_LEN    = WIDTH,
   parameter bit               STOP_ON_DONE = 1'b1
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Clear,
   input  logic                      Load,
   input  logic                      Shift,
   input  logic                      Dir,
   input  logic                      Rotate,
   input  logic                      Sin,
   input  logic [WIDTH-1:0]          D,
   output logic [WIDTH-1:0]          Q,
   output logic                      Sout,
   output logic [cnt_w(WIDTH)-1:0]   ShiftCount,
   output logic                      Done
);

   localparam int CW = cnt_w(WIDTH);

   logic [WIDTH-1:0] q_q, q_d;
   sr_op_t           op;
   shift_dir_t       dir;
   logic             exit_bit;
   logic             in_bit;

   assign dir      = shift_dir_t'(Dir);
   assign exit_bit = (dir == SHIFT_LEFT) ? q_q[WIDTH-1] : q_q[0];
   assign in_bit   = Rotate ? exit_bit : Sin;

   always_comb begin
      op = OP_HOLD;
      if (Clear) begin
         op = OP_CLEAR;
      end else if (Load) begin
         op = OP_LOAD;
      end else if (Shift && !(STOP_ON_DONE && Done)) begin
         op = OP_SHIFT;
      end
   end

   always_comb begin
      q_d = q_q;
      case (op)
         OP_CLEAR: q_d = RESET_VAL;
         OP_LOAD:  q_d = D;
         OP_SHIFT: begin
            if (dir == SHIFT_LEFT) begin
               q_d = {q_q[WIDTH-2:0], in_bit};
            end else begin
               q_d = {in_bit, q_q[WIDTH-1:1]};
            end
         end
         default:  q_d = q_q;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   shift_counter #(
      .MAX  (SHIFT_LEN),
      .STOP (STOP_ON_DONE),
      .CW   (CW)
   ) u_counter (
      .Clk   (Clk),
      .Reset (Reset),
      .Inc   (op == OP_SHIFT),
      .Zero  ((op == OP_CLEAR) || (op == OP_LOAD)),
      .Count (ShiftCount),
      .Done  (Done)
   );

   assign Q    = q_q;
   assign Sout = exit_bit;

endmodule

// File: tb/tb_shift_reg_n.sv
// Bench for shift_reg_n: directed plan steps plus random traffic against an
// arithmetic reference model, on two 8-bit variants and one 16-bit variant.
module tb_shift_reg_n;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Clear = 1'b0;
   logic        Load = 1'b0;
   logic        Shift = 1'b0;
   logic        Dir = 1'b0;
   logic        Rotate = 1'b0;
   logic        Sin = 1'b0;
   logic [7:0]  d8 = '0;
   logic [15:0] d16 = '0;

   logic [7:0]  q_a, q_b;
   logic [15:0] q_c;
   logic        sout_a, sout_b, sout_c;
   logic [3:0]  cnt_a, cnt_b;
   logic [4:0]  cnt_c;
   logic        done_a, done_b, done_c;

   int passed = 0;
   int total  = 0;

   // Reference model state: index 0 = 8-bit stop, 1 = 8-bit no-stop, 2 = 16-bit
   logic [31:0] mq [3];
   int          mc [3];
   int          mw   [3] = '{8, 8, 16};
   int          mlen [3] = '{8, 8, 4};
   bit          mstop[3] = '{1'b1, 1'b0, 1'b1};

   always #5 Clk = ~Clk;

   shift_reg_n #(.WIDTH(8), .SHIFT_LEN(8), .STOP_ON_DONE(1'b1)) dut_a (
      .Clk(Clk), .Reset(Reset), .Clear(Clear), .Load(Load), .Shift(Shift),
      .Dir(Dir), .Rotate(Rotate), .Sin(Sin), .D(d8), .Q(q_a), .Sout(sout_a),
      .ShiftCount(cnt_a), .Done(done_a));

   shift_reg_n #(.WIDTH(8), .SHIFT_LEN(8), .STOP_ON_DONE(1'b0)) dut_b (
      .Clk(Clk), .Reset(Reset), .Clear(Clear), .Load(Load), .Shift(Shift),
      .Dir(Dir), .Rotate(Rotate), .Sin(Sin), .D(d8), .Q(q_b), .Sout(sout_b),
      .ShiftCount(cnt_b), .Done(done_b));

   shift_reg_n #(.WIDTH(16), .SHIFT_LEN(4), .STOP_ON_DONE(1'b1)) dut_c (
      .Clk(Clk), .Reset(Reset), .Clear(Clear), .Load(Load), .Shift(Shift),
      .Dir(Dir), .Rotate(Rotate), .Sin(Sin), .D(d16), .Q(q_c), .Sout(sout_c),
      .ShiftCount(cnt_c), .Done(done_c));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i] = 32'd0;
         mc[i] = 0;
      end
   endtask

   // One clock edge of the behaviour, written as value arithmetic.
   task automatic model_edge(input int i, input logic [31:0] d);
      logic [31:0] mask, q, ex, inb;
      mask = (32'd1 << mw[i]) - 32'd1;
      q    = mq[i];
      if (Clear) begin
         mq[i] = 32'd0;
         mc[i] = 0;
      end else if (Load) begin
         mq[i] = d & mask;
         mc[i] = 0;
      end else if (Shift && !(mstop[i] && mc[i] == mlen[i])) begin
         if (!Dir) begin
            ex  = q & 32'd1;
            inb = Rotate ? ex : 32'(Sin);
            q   = (q >> 1) | (inb << (mw[i] - 1));
         end else begin
            ex  = (q >> (mw[i] - 1)) & 32'd1;
            inb = Rotate ? ex : 32'(Sin);
            q   = ((q << 1) & mask) | inb;
         end
         mq[i] = q;
         mc[i] = (mc[i] + 1 > mlen[i]) ? mlen[i] : mc[i] + 1;
      end
   endtask

   function automatic logic [31:0] model_sout(input int i);
      return Dir ? ((mq[i] >> (mw[i] - 1)) & 32'd1) : (mq[i] & 32'd1);
   endfunction

   task automatic check_all(input string step);
      check({step, " q_a"},    32'(q_a),    mq[0]);
      check({step, " cnt_a"},  32'(cnt_a),  32'(mc[0]));
      check({step, " done_a"}, 32'(done_a), 32'(mc[0] == mlen[0]));
      check({step, " sout_a"}, 32'(sout_a), model_sout(0));
      check({step, " q_b"},    32'(q_b),    mq[1]);
      check({step, " cnt_b"},  32'(cnt_b),  32'(mc[1]));
      check({step, " done_b"}, 32'(done_b), 32'(mc[1] == mlen[1]));
      check({step, " sout_b"}, 32'(sout_b), model_sout(1));
      check({step, " q_c"},    32'(q_c),    mq[2]);
      check({step, " cnt_c"},  32'(cnt_c),  32'(mc[2]));
      check({step, " done_c"}, 32'(done_c), 32'(mc[2] == mlen[2]));
      check({step, " sout_c"}, 32'(sout_c), model_sout(2));
   endtask

   task automatic tick(input string step);
      @(posedge Clk);
      model_edge(0, 32'(d8));
      model_edge(1, 32'(d8));
      model_edge(2, 32'(d16));
      #1;
      $display("%s: clr=%b ld=%b sh=%b dir=%b rot=%b sin=%b q_a=%h cnt_a=%0d done_a=%b q_c=%h",
               step, Clear, Load, Shift, Dir, Rotate, Sin, q_a, cnt_a, done_a, q_c);
      check_all(step);
   endtask

   task automatic set_ctl(input logic c, input logic l, input logic s,
                          input logic dr, input logic r, input logic si);
      Clear = c; Load = l; Shift = s; Dir = dr; Rotate = r; Sin = si;
   endtask

   logic [7:0] sout_seq;

   initial begin
      model_reset();
      #12;
      check("reset q_a", 32'(q_a), 32'h0);
      check("reset cnt_a", 32'(cnt_a), 32'h0);
      check("reset done_a", 32'(done_a), 32'h0);
      Reset = 1'b0;

      // Load then logical right shift; Sout bits in exit order
      sout_seq = 8'b1011_0010;
      d8 = 8'b1011_0010; d16 = 16'h1234;
      set_ctl(0, 1, 0, 0, 0, 0);
      tick("load b2");
      set_ctl(0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("sout seq %0d", k), 32'(sout_a), 32'(sout_seq[k]));
         check($sformatf("done pre %0d", k), 32'(done_a), 32'h0);
         tick($sformatf("shr %0d", k));
      end
      check("shr final q", 32'(q_a), 32'h00);
      check("shr final cnt", 32'(cnt_a), 32'd8);
      check("shr final done", 32'(done_a), 32'h1);

      // Shift held after Done: stop variant frozen, no-stop variant keeps going
      set_ctl(0, 0, 1, 0, 0, 1);
      for (int k = 0; k < 4; k++) tick($sformatf("post done %0d", k));
      check("stop q held", 32'(q_a), 32'h00);
      check("stop cnt held", 32'(cnt_a), 32'd8);
      check("nostop q", 32'(q_b), 32'hF0);
      check("nostop cnt sat", 32'(cnt_b), 32'd8);
      d8 = 8'h55;
      set_ctl(0, 1, 0, 0, 0, 0);
      tick("load 55");
      check("load clears done", 32'(done_a), 32'h0);

      // Rotate left
      d8 = 8'h81;
      tick("load 81");
      set_ctl(0, 0, 1, 1, 1, 0);
      for (int k = 0; k < 3; k++) tick($sformatf("rol %0d", k));
      check("rol q", 32'(q_a), 32'h0C);
      check("rol cnt", 32'(cnt_a), 32'd3);
      check("rol done", 32'(done_a), 32'h0);

      // Priority
      d8 = 8'h3C;
      set_ctl(0, 1, 1, 0, 0, 1);
      tick("load+shift");
      check("load beats shift", 32'(q_a), 32'h3C);
      check("load beats shift cnt", 32'(cnt_a), 32'd0);
      d8 = 8'hFF;
      set_ctl(1, 1, 0, 0, 0, 0);
      tick("clear+load");
      check("clear beats load", 32'(q_a), 32'h00);

      // 16-bit left logical fill with ones
      d16 = 16'h0000;
      set_ctl(0, 1, 0, 0, 0, 0);
      tick("load16");
      set_ctl(0, 0, 1, 1, 0, 1);
      for (int k = 0; k < 4; k++) tick($sformatf("shl16 %0d", k));
      check("w16 q", 32'(q_c), 32'h000F);
      check("w16 done", 32'(done_c), 32'h1);

      // Random traffic
      for (int k = 0; k < 400; k++) begin
         set_ctl($urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
         d8  = 8'($urandom);
         d16 = 16'($urandom);
         tick($sformatf("rand %0d", k));
      end

      // Asynchronous reset mid-cycle
      d8 = 8'hA5; d16 = 16'hA5A5;
      set_ctl(0, 1, 0, 0, 0, 0);
      tick("load a5");
      check("pre reset q", 32'(q_a), 32'hA5);
      set_ctl(0, 0, 0, 0, 0, 0);
      #2 Reset = 1'b1;
      #1;
      model_reset();
      check("async q", 32'(q_a), 32'h00);
      check("async cnt", 32'(cnt_a), 32'h0);
      check("async done", 32'(done_a), 32'h0);
      check("async q16", 32'(q_c), 32'h0000);
      #2 Reset = 1'b0;
      tick("after reset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
